// File: rtl/prog_rom_banked_if.sv
// Fetch and loader bundle between the PC/fetch stage, the program source and the banked ROM.
// Latency: none, wiring only.
// Backpressure: none here; the source must watch busy and stall fetches while a load runs.
interface prog_rom_banked_if #(
    parameter int DATA_W = 13,
    parameter int ADDR_W = 8,
    parameter int BANK_W = 1
);
    logic [BANK_W-1:0] bank_sel;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_err;
    logic              ld_start;
    logic              ld_we;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              ld_done;
    logic              busy;

    modport master (
        output bank_sel, rd_req, rd_addr, ld_start, ld_we, ld_data, ld_last,
        input  rd_data, rd_valid, rd_err, ld_done, busy
    );

    modport slave (
        input  bank_sel, rd_req, rd_addr, ld_start, ld_we, ld_data, ld_last,
        output rd_data, rd_valid, rd_err, ld_done, busy
    );
endinterface

// File: rtl/prog_rom_banked.sv
// Multi-bank loadable program memory with per-bank length tracking and a streaming loader.
// Latency: fetch rd_req -> rd_data/rd_valid one cycle later; one load word accepted per cycle.
// Backpressure: none; fetches are dropped while busy, so the core must stall on busy.
module prog_rom_banked #(
    parameter int                DATA_W = 13,
    parameter int                ADDR_W = 8,
    parameter int                DEPTH  = 256,
    parameter int                BANK_W = 1,
    parameter logic [DATA_W-1:0] FILL   = '0
) (
    input  logic                clk,
    input  logic                rst,
    prog_rom_banked_if.slave    bus
);
    localparam int NBANK = 1 << BANK_W;
    localparam int LEN_W = ADDR_W + 1;
    localparam int MA_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {S_IDLE, S_LOAD} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mem [NBANK][DEPTH];
    logic [LEN_W-1:0]  len [NBANK];
    logic [ADDR_W-1:0] wptr;
    logic [BANK_W-1:0] lbank;
    logic              do_read, do_write, do_end;
    logic              rd_hit;

    // len never exceeds DEPTH, so a single compare also covers addresses past the bank depth
    assign rd_hit   = {1'b0, bus.rd_addr} < len[bus.bank_sel];
    assign bus.busy = (state_q == S_LOAD);

    // Next state and per-cycle actions; ld_start outranks both fetches and load writes
    always_comb begin
        state_d  = state_q;
        do_read  = 1'b0;
        do_write = 1'b0;
        do_end   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.ld_start) state_d = S_LOAD;
                else              do_read = bus.rd_req;
            end
            S_LOAD: begin
                if (bus.ld_start) begin
                    state_d = S_LOAD;
                end else if (bus.ld_we) begin
                    do_write = 1'b1;
                    if (bus.ld_last || wptr == ADDR_W'(DEPTH - 1)) begin
                        do_end  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, fetch pipeline register and loader bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            bus.rd_data  <= '0;
            bus.rd_valid <= 1'b0;
            bus.rd_err   <= 1'b0;
            bus.ld_done  <= 1'b0;
            wptr         <= '0;
            lbank        <= '0;
            for (int b = 0; b < NBANK; b++) len[b] <= '0;
        end else begin
            state_q      <= state_d;
            bus.rd_valid <= do_read;
            bus.rd_err   <= do_read && !rd_hit;
            bus.ld_done  <= do_end;
            if (do_read)
                bus.rd_data <= rd_hit ? mem[bus.bank_sel][bus.rd_addr[MA_W-1:0]] : FILL;
            if (bus.ld_start) begin
                // the bank under load reads as empty until its final word lands
                lbank               <= bus.bank_sel;
                wptr                <= '0;
                len[bus.bank_sel]   <= '0;
            end else if (do_write) begin
                wptr <= wptr + ADDR_W'(1);
                if (do_end) len[lbank] <= {1'b0, wptr} + LEN_W'(1);
            end
        end
    end

    // Program storage write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (!rst && do_write) mem[lbank][wptr[MA_W-1:0]] <= bus.ld_data;
    end
endmodule

// File: tb/tb_prog_rom_banked.sv
// Directed bench for prog_rom_banked: default build plus a DEPTH=4 build for overflow.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: none; stimulus honours busy only where the test intends to.
module tb_prog_rom_banked;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    prog_rom_banked_if #(.DATA_W(13), .ADDR_W(8), .BANK_W(1)) b ();
    prog_rom_banked_if #(.DATA_W(13), .ADDR_W(8), .BANK_W(1)) s ();

    prog_rom_banked #(.DATA_W(13), .ADDR_W(8), .DEPTH(256), .BANK_W(1), .FILL(13'h0))
        u_dut (.clk(clk), .rst(rst), .bus(b));
    prog_rom_banked #(.DATA_W(13), .ADDR_W(8), .DEPTH(4), .BANK_W(1), .FILL(13'h0))
        u_small (.clk(clk), .rst(rst), .bus(s));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ld_begin(input logic bank);
        b.bank_sel = bank;
        b.ld_start = 1'b1;
        tick();
        b.ld_start = 1'b0;
        check("ld_busy", b.busy, 1);
    endtask

    task automatic ld_word(input logic [12:0] d, input logic last, input string tag);
        b.ld_we   = 1'b1;
        b.ld_data = d;
        b.ld_last = last;
        tick();
        b.ld_we   = 1'b0;
        b.ld_last = 1'b0;
        check({tag, "_done"}, b.ld_done, last);
        check({tag, "_busy"}, b.busy, !last);
    endtask

    task automatic rd(input logic bank, input logic [7:0] a, input logic [12:0] d,
                      input logic err, input string tag);
        b.bank_sel = bank;
        b.rd_addr  = a;
        b.rd_req   = 1'b1;
        tick();
        b.rd_req   = 1'b0;
        check({tag, "_vld"}, b.rd_valid, 1);
        check({tag, "_dat"}, b.rd_data, d);
        check({tag, "_err"}, b.rd_err, err);
    endtask

    initial begin
        b.bank_sel = 0; b.rd_req = 0; b.rd_addr = 0; b.ld_start = 0;
        b.ld_we = 0; b.ld_data = 0; b.ld_last = 0;
        s.bank_sel = 0; s.rd_req = 0; s.rd_addr = 0; s.ld_start = 0;
        s.ld_we = 0; s.ld_data = 0; s.ld_last = 0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_vld",  b.rd_valid, 0);
        check("rst_err",  b.rd_err, 0);
        check("rst_dat",  b.rd_data, 0);
        check("rst_busy", b.busy, 0);
        check("rst_done", b.ld_done, 0);

        // T1: load bank0, then back-to-back fetches
        ld_begin(0);
        ld_word(13'h1D00, 0, "t1_w0");
        ld_word(13'h1200, 0, "t1_w1");
        ld_word(13'h1100, 1, "t1_w2");
        tick();
        check("t1_done_pulse", b.ld_done, 0);
        b.bank_sel = 0;
        b.rd_req = 1'b1;
        begin
            logic [12:0] exp_w [3];
            exp_w[0] = 13'h1D00; exp_w[1] = 13'h1200; exp_w[2] = 13'h1100;
            for (int i = 0; i < 3; i++) begin
                b.rd_addr = 8'(i);
                tick();
                check("t1_vld", b.rd_valid, 1);
                check("t1_dat", b.rd_data, exp_w[i]);
                check("t1_err", b.rd_err, 0);
            end
        end
        b.rd_req = 1'b0;
        tick();
        check("t1_idle_vld", b.rd_valid, 0);
        check("t1_hold_dat", b.rd_data, 13'h1100);

        // T2: past end of bank0
        rd(0, 8'd3, 13'h0, 1, "t2");

        // T3: bank1 load, banks independent
        ld_begin(1);
        ld_word(13'h1100, 0, "t3_w0");
        ld_word(13'h1E00, 1, "t3_w1");
        rd(0, 8'd0, 13'h1D00, 0, "t3_b0a0");
        rd(1, 8'd1, 13'h1E00, 0, "t3_b1a1");
        rd(1, 8'd2, 13'h0000, 1, "t3_b1a2");
        rd(1, 8'd0, 13'h1100, 0, "t3_b1a0");

        // T4: fetch held during reload of bank0; ld_start beats rd_req
        b.bank_sel = 0; b.rd_addr = 8'd0; b.rd_req = 1'b1; b.ld_start = 1'b1;
        tick();
        b.ld_start = 1'b0;
        check("t4_start_vld", b.rd_valid, 0);
        check("t4_busy", b.busy, 1);
        b.ld_we = 1'b1; b.ld_data = 13'h0ABC;
        tick();
        check("t4_w0_vld", b.rd_valid, 0);
        check("t4_w0_busy", b.busy, 1);
        b.ld_data = 13'h0DEF; b.ld_last = 1'b1;
        tick();
        b.ld_we = 1'b0; b.ld_last = 1'b0;
        check("t4_w1_vld", b.rd_valid, 0);
        check("t4_w1_done", b.ld_done, 1);
        tick();
        b.rd_req = 1'b0;
        check("t4_new_vld", b.rd_valid, 1);
        check("t4_new_dat", b.rd_data, 13'h0ABC);
        // ld_we outside a load is ignored
        b.ld_we = 1'b1; b.ld_data = 13'h1FFF;
        tick();
        b.ld_we = 1'b0;
        check("t4_idle_we_done", b.ld_done, 0);
        check("t4_idle_we_busy", b.busy, 0);
        rd(0, 8'd1, 13'h0DEF, 0, "t4_b0a1");
        rd(0, 8'd2, 13'h0000, 1, "t4_b0a2");

        // restart mid-load of bank1; word coinciding with ld_start is dropped
        ld_begin(1);
        ld_word(13'h0111, 0, "rs_w0");
        b.bank_sel = 1; b.ld_start = 1'b1; b.ld_we = 1'b1; b.ld_data = 13'h0222;
        tick();
        b.ld_start = 1'b0; b.ld_we = 1'b0;
        check("rs_restart_busy", b.busy, 1);
        check("rs_restart_done", b.ld_done, 0);
        ld_word(13'h0333, 1, "rs_w1");
        rd(1, 8'd0, 13'h0333, 0, "rs_b1a0");
        rd(1, 8'd1, 13'h0000, 1, "rs_b1a1");

        // T5: reset mid-load
        ld_begin(0);
        ld_word(13'h0AAA, 0, "t5_w0");
        ld_word(13'h0BBB, 0, "t5_w1");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_busy", b.busy, 0);
        check("t5_done", b.ld_done, 0);
        check("t5_vld", b.rd_valid, 0);
        tick();
        check("t5_done_later", b.ld_done, 0);
        rd(0, 8'd0, 13'h0000, 1, "t5_b0a0");
        rd(1, 8'd0, 13'h0000, 1, "t5_b1a0");

        // T6: DEPTH=4 overflow terminates load on the 4th write
        s.bank_sel = 0; s.ld_start = 1'b1;
        tick();
        s.ld_start = 1'b0;
        check("t6_busy", s.busy, 1);
        for (int i = 0; i < 6; i++) begin
            s.ld_we = 1'b1;
            s.ld_data = 13'h1001 + 13'(i);
            tick();
            check("t6_done", s.ld_done, (i == 3) ? 1 : 0);
            check("t6_busy_w", s.busy, (i < 3) ? 1 : 0);
        end
        s.ld_we = 1'b0;
        s.rd_addr = 8'd3; s.rd_req = 1'b1;
        tick();
        check("t6_a3_vld", s.rd_valid, 1);
        check("t6_a3_dat", s.rd_data, 13'h1004);
        check("t6_a3_err", s.rd_err, 0);
        s.rd_addr = 8'd4;
        tick();
        check("t6_a4_err", s.rd_err, 1);
        check("t6_a4_dat", s.rd_data, 13'h0000);
        s.rd_addr = 8'd0;
        tick();
        s.rd_req = 1'b0;
        check("t6_a0_dat", s.rd_data, 13'h1001);
        check("t6_a0_err", s.rd_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
